shift_add_rescaler: RTL

- Inverse of the two-term shift-add scaler. The forward scaler computes `shifted = (x>>bit_1) + (bit_2!=0 ? x>>bit_2 : 0)`.
- This block takes a scaled value `y` and the same shift codes, and recovers `x ≈ y / (2^-bit_1 + 2^-bit_2)`.
- It uses a multicycle restoring divider with a start/valid handshake.
- It sits downstream of the scaler, where the datapath must undo a gain stage.

---
 rtl/shift_add_rescaler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/shift_add_rescaler.sv
// Inverse of the two-term shift-add scaler: restored = sat(floor((y << (WIDTH-1)) / D)),
// where D = 2^(WIDTH-1-bit_1) + (bit_2 != 0 ? 2^(WIDTH-1-bit_2) : 0). Multicycle restoring divider.
module shift_add_rescaler #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   bit_1,
  input  logic [SHW-1:0]   bit_2,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] restored,
  output logic             ovf
);

  localparam int unsigned QW   = 2 * WIDTH - 1;
  localparam int unsigned CW   = $clog2(QW);
  localparam int unsigned LAST = QW - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   b1_q, b1_d;
  logic [SHW-1:0]   b2_q, b2_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [QW-1:0]    quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] restored_q, restored_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_step;
  logic [QW-1:0]    quo_step;
  logic             sat;
  logic [WIDTH-1:0] term_1;
  logic [WIDTH-1:0] term_2;

  // One restoring step on {rem, quo}; rem stays below D < 2^WIDTH so the shifted value needs WIDTH+1 bits
  always_comb begin
    rem_sh   = {rem_q, quo_q[QW-1]};
    rem_ge   = (rem_sh >= {1'b0, div_q});
    rem_step = rem_ge ? WIDTH'(rem_sh - {1'b0, div_q}) : WIDTH'(rem_sh);
    quo_step = {quo_q[QW-2:0], rem_ge};
    sat      = |quo_step[QW-1:WIDTH];
    term_1   = WIDTH'(1) << (SHW'(WIDTH - 1) - b1_q);
    term_2   = (b2_q != '0) ? (WIDTH'(1) << (SHW'(WIDTH - 1) - b2_q)) : '0;
  end

  // Next-state and next-register logic
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    b1_d       = b1_q;
    b2_d       = b2_q;
    div_d      = div_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    restored_d = restored_q;
    ovf_d      = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = data_in;
          b1_d    = bit_1;
          b2_d    = bit_2;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        div_d   = term_1 + term_2;
        rem_d   = '0;
        quo_d   = {data_q, (WIDTH - 1)'(0)};
        cnt_d   = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LAST)) begin
          busy_d     = 1'b0;
          valid_d    = 1'b1;
          restored_d = sat ? '1 : quo_step[WIDTH-1:0];
          ovf_d      = sat;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      div_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      restored_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      div_q      <= div_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      restored_q <= restored_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign restored = restored_q;
  assign ovf      = ovf_q;

endmodule
